mem_writer: RTL and testbench

Byte-serial memory store engine for the real-mode x86 core: the write-side counterpart of the core's byte-by-byte memory operand fetch. It accepts a store request (segment, 16-bit effective address, 8/16/32-bit data), buffers one further request, and drives the shared byte bus (`address`, `o_data`, `we`) one byte per cycle, little-endian. Sits between the core's EXEC/writeback phase and the memory bus mux; `bus_own` tells the mux to select this block.

---
 rtl/x86_pkg.sv | 62 ++++++
 rtl/mw_slot.sv | 21 ++
 rtl/mem_writer.sv | 129 ++++++++++++
 tb/tb_mem_writer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/x86_pkg.sv
// Shared real-mode x86 definitions: operand size encodings, store request
// payloads and real-mode address helpers.
package x86_pkg;

    localparam int unsigned SEG_W  = 16;
    localparam int unsigned EA_W   = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LIN_W  = 20;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned KIDX_W = 2;

    localparam logic [SIZE_W-1:0] SZ_BYTE  = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_WORD  = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_DWORD = 2'd2;

    typedef enum logic {
        MW_IDLE  = 1'b0,
        MW_WRITE = 1'b1
    } mw_state_t;

    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic [SEG_W-1:0]  seg;
        logic [EA_W-1:0]   ea;
        logic [DATA_W-1:0] data;
    } store_req_t;

    // One buffered store plus the precomputed bus view of its current byte.
    typedef struct packed {
        store_req_t        req;
        logic [KIDX_W-1:0] k;
        logic [LIN_W-1:0]  addr;
        logic [7:0]        data_byte;
    } mw_slot_t;

    // Index of the final byte for a size code; code 3 behaves as a dword.
    function automatic logic [KIDX_W-1:0] last_index(input logic [SIZE_W-1:0] size);
        case (size)
            SZ_BYTE: return 2'd0;
            SZ_WORD: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Real-mode linear address; carries into bits 19:16, no A20 masking.
    function automatic logic [LIN_W-1:0] linear(input logic [SEG_W-1:0] seg,
                                                input logic [EA_W-1:0]  ea);
        return {seg, 4'b0000} + LIN_W'(ea);
    endfunction

    // Slot contents positioned at byte k; the offset wraps inside the segment.
    function automatic mw_slot_t slot_at(input store_req_t req,
                                         input logic [KIDX_W-1:0] k);
        mw_slot_t s;
        s.req       = req;
        s.k         = k;
        s.addr      = linear(req.seg, req.ea + EA_W'(k));
        s.data_byte = req.data[{k, 3'b000} +: 8];
        return s;
    endfunction

endpackage

// File: rtl/mw_slot.sv
// Storage for one store request (fields, byte index, current byte view).
module mw_slot
    import x86_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     load,
    input  mw_slot_t d,
    output mw_slot_t q
);

    // Load-enabled slot register, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_writer.sv
// Byte-serial store engine: one active request plus a one-deep buffer,
// written little-endian onto the shared byte bus, one byte per en cycle.
module mem_writer
    import x86_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_size,
    input  logic [15:0]       req_seg,
    input  logic [15:0]       req_ea,
    input  logic [31:0]       req_data,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        o_data,
    output logic              we,
    output logic              bus_own,
    output logic              busy,
    output logic              done
);

    mw_state_t         state;
    logic              pend_full;
    mw_slot_t          cur;
    mw_slot_t          pend;
    mw_slot_t          new_slot;
    mw_slot_t          cur_d;
    store_req_t        new_req;
    logic              accept;
    logic              active;
    logic              at_last;
    logic              cur_load;
    logic              cur_adv;
    logic              pend_load;
    logic              promote;
    logic [KIDX_W-1:0] k_next;

    assign new_req  = '{size: req_size, seg: req_seg, ea: req_ea, data: req_data};
    assign new_slot = slot_at(new_req, 2'd0);

    assign req_ready = en && !pend_full;
    assign accept    = req_valid && req_ready;
    assign active    = (state == MW_WRITE);
    assign at_last   = (cur.k == last_index(cur.req.size));
    assign k_next    = cur.k + 2'd1;

    assign we      = active && en;
    assign bus_own = we;
    assign done    = we && at_last;
    assign busy    = active || pend_full;

    assign address = ADDR_W'(cur.addr);
    assign o_data  = cur.data_byte;

    // Slot steering: advance, refill from pend or from the request port.
    always_comb begin
        cur_load  = 1'b0;
        cur_adv   = 1'b0;
        pend_load = 1'b0;
        promote   = 1'b0;
        if (en && active) begin
            if (!at_last) begin
                cur_adv   = 1'b1;
                pend_load = accept;
            end else if (pend_full) begin
                promote   = 1'b1;
                cur_load  = 1'b1;
                pend_load = accept;
            end else begin
                cur_load = accept;
            end
        end else if (en) begin
            cur_load = accept;
        end
    end

    // Next contents of the active slot.
    always_comb begin
        cur_d = cur;
        if (cur_load) begin
            cur_d = promote ? pend : new_slot;
        end else if (cur_adv) begin
            cur_d = slot_at(cur.req, k_next);
        end
    end

    // Write sequencer and pend occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= MW_IDLE;
            pend_full <= 1'b0;
        end else if (en) begin
            case (state)
                MW_IDLE: begin
                    if (accept) begin
                        state <= MW_WRITE;
                    end
                end
                MW_WRITE: begin
                    if (at_last && !pend_full && !accept) begin
                        state <= MW_IDLE;
                    end
                end
                default: state <= MW_IDLE;
            endcase
            pend_full <= pend_load || (pend_full && !promote);
        end
    end

    mw_slot u_cur (
        .clock (clock),
        .reset (reset),
        .load  (cur_load || cur_adv),
        .d     (cur_d),
        .q     (cur)
    );

    mw_slot u_pend (
        .clock (clock),
        .reset (reset),
        .load  (pend_load),
        .d     (new_slot),
        .q     (pend)
    );

endmodule

// File: tb/tb_mem_writer.sv
// Directed self-checking bench for mem_writer.
module tb_mem_writer;

    logic        clock;
    logic        reset;
    logic        en;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_size;
    logic [15:0] req_seg;
    logic [15:0] req_ea;
    logic [31:0] req_data;
    logic [31:0] address;
    logic [7:0]  o_data;
    logic        we;
    logic        bus_own;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    mem_writer #(.ADDR_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_size  (req_size),
        .req_seg   (req_seg),
        .req_ea    (req_ea),
        .req_data  (req_data),
        .address   (address),
        .o_data    (o_data),
        .we        (we),
        .bus_own   (bus_own),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the active edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic drive_req(input logic [1:0] size, input logic [15:0] seg,
                             input logic [15:0] ea, input logic [31:0] data);
        req_size  = size;
        req_seg   = seg;
        req_ea    = ea;
        req_data  = data;
        req_valid = 1'b1;
    endtask

    task automatic expect_byte(input string tag, input logic [31:0] a,
                               input logic [7:0] d, input logic dn);
        check({tag, "_we"}, 32'(we), 32'd1);
        check({tag, "_own"}, 32'(bus_own), 32'd1);
        check({tag, "_addr"}, address, a);
        check({tag, "_data"}, 32'(o_data), 32'(d));
        check({tag, "_done"}, 32'(done), 32'(dn));
    endtask

    task automatic expect_quiet(input string tag);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        en        = 1'b1;
        req_valid = 1'b0;
        req_size  = 2'd0;
        req_seg   = 16'h0;
        req_ea    = 16'h0;
        req_data  = 32'h0;

        // Reset state
        sample();
        expect_quiet("rst");
        check("rst_own", 32'(bus_own), 32'd0);
        check("rst_addr", address, 32'h0);
        check("rst_data", 32'(o_data), 32'h0);
        check("rst_ready", 32'(req_ready), 32'd1);
        en = 1'b0;
        #1;
        check("rst_ready_en0", 32'(req_ready), 32'd0);
        en = 1'b1;
        next_cycle();
        reset = 1'b0;
        sample();
        expect_quiet("idle");

        // Byte store 1234h:0010h
        next_cycle();
        drive_req(2'd0, 16'h1234, 16'h0010, 32'h0000_00A5);
        next_cycle();
        req_valid = 1'b0;
        sample();
        expect_byte("byte", 32'h12350, 8'hA5, 1'b1);
        next_cycle();
        sample();
        expect_quiet("byte_end");

        // Dword with offset wrap 0000h:FFFEh
        next_cycle();
        drive_req(2'd2, 16'h0000, 16'hFFFE, 32'h4433_2211);
        next_cycle();
        req_valid = 1'b0;
        sample(); expect_byte("dw_b0", 32'h0FFFE, 8'h11, 1'b0);
        next_cycle(); sample(); expect_byte("dw_b1", 32'h0FFFF, 8'h22, 1'b0);
        next_cycle(); sample(); expect_byte("dw_b2", 32'h00000, 8'h33, 1'b0);
        next_cycle(); sample(); expect_byte("dw_b3", 32'h00001, 8'h44, 1'b1);
        next_cycle(); sample(); expect_quiet("dw_end");

        // Two back-to-back words, second buffered in pend
        next_cycle();
        drive_req(2'd1, 16'h1000, 16'h0000, 32'h0000_BBAA);
        next_cycle();
        drive_req(2'd1, 16'h2000, 16'h0002, 32'h0000_DDCC);
        sample();
        expect_byte("w2_b0", 32'h10000, 8'hAA, 1'b0);
        check("w2_ready", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        sample();
        expect_byte("w2_b1", 32'h10001, 8'hBB, 1'b1);
        check("w2_busy", 32'(busy), 32'd1);
        next_cycle(); sample(); expect_byte("w2_b2", 32'h20002, 8'hCC, 1'b0);
        next_cycle(); sample(); expect_byte("w2_b3", 32'h20003, 8'hDD, 1'b1);
        next_cycle(); sample(); expect_quiet("w2_end");

        // Three dwords: pend full stalls the third until pend drains
        next_cycle();
        drive_req(2'd2, 16'h0100, 16'h0000, 32'h0302_0100);
        next_cycle();
        for (int i = 0; i < 12; i++) begin
            if (i == 0) drive_req(2'd2, 16'h0200, 16'h0000, 32'h1312_1110);
            if (i == 1) drive_req(2'd2, 16'h0300, 16'h0000, 32'h2322_2120);
            if (i == 5) req_valid = 1'b0;
            sample();
            expect_byte($sformatf("dw3_%0d", i),
                        32'((i / 4 + 1) * 32'h1000 + (i % 4)),
                        8'((i / 4) * 16 + (i % 4)),
                        1'((i % 4) == 3));
            check($sformatf("dw3_ready_%0d", i), 32'(req_ready),
                  32'(i == 0 || i == 4 || i >= 8));
            next_cycle();
        end
        sample();
        expect_quiet("dw3_end");

        // en stall after byte 1 of a dword
        next_cycle();
        drive_req(2'd2, 16'h0500, 16'h0010, 32'hDDCC_BBAA);
        next_cycle();
        req_valid = 1'b0;
        sample(); expect_byte("st_b0", 32'h05010, 8'hAA, 1'b0);
        next_cycle(); sample(); expect_byte("st_b1", 32'h05011, 8'hBB, 1'b0);
        next_cycle();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("st_we_%0d", i), 32'(we), 32'd0);
            check($sformatf("st_done_%0d", i), 32'(done), 32'd0);
            check($sformatf("st_ready_%0d", i), 32'(req_ready), 32'd0);
            check($sformatf("st_busy_%0d", i), 32'(busy), 32'd1);
            check($sformatf("st_addr_%0d", i), address, 32'h05012);
            next_cycle();
        end
        en = 1'b1;
        sample(); expect_byte("st_b2", 32'h05012, 8'hCC, 1'b0);
        next_cycle(); sample(); expect_byte("st_b3", 32'h05013, 8'hDD, 1'b1);
        next_cycle(); sample(); expect_quiet("st_end");

        // Reset mid-dword with pend full
        next_cycle();
        drive_req(2'd2, 16'h0600, 16'h0000, 32'h3322_1100);
        next_cycle();
        drive_req(2'd2, 16'h0700, 16'h0000, 32'h7766_5544);
        sample(); expect_byte("rs_b0", 32'h06000, 8'h00, 1'b0);
        next_cycle();
        req_valid = 1'b0;
        sample();
        expect_byte("rs_b1", 32'h06001, 8'h11, 1'b0);
        check("rs_ready_full", 32'(req_ready), 32'd0);
        next_cycle();
        reset = 1'b1;
        #1;
        expect_quiet("rs_now");
        check("rs_addr", address, 32'h0);
        check("rs_data", 32'(o_data), 32'h0);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            check($sformatf("rs_idle_we_%0d", i), 32'(we), 32'd0);
            check($sformatf("rs_idle_busy_%0d", i), 32'(busy), 32'd0);
            next_cycle();
        end
        drive_req(2'd0, 16'h0000, 16'h0042, 32'hFFFF_FF5A);
        next_cycle();
        req_valid = 1'b0;
        sample(); expect_byte("rs_new", 32'h00042, 8'h5A, 1'b1);
        next_cycle(); sample(); expect_quiet("rs_new_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
